// File: rtl/qea_core.sv
// qea_core: quantum-circuit emulation engine; gate list and 2^n state vector are host-loaded, gates applied in place on i_start.
// Latency: 6-cycle gate fetch, then 3 cycles per processed row pair (1 per skipped partner row); o_complete level when done.
// Backpressure: none; host state/ctx ports and i_start are ignored while a run is in progress.
module qea_core #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 1 << PE_NUM_WIDTH,
  parameter int DATA_WIDTH              = 32,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int ALU_DATA_WIDTH          = DATA_WIDTH,
  parameter int STATE_DATA_WIDTH        = 2 * DATA_WIDTH,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_DATA_WIDTH         = 2 * DATA_WIDTH,
  parameter int GATE_ADDR_WIDTH         = 6,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int NUM_FRAC_BIT            = 30
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_start,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic                                 i_ctx_en,
  input  logic                                 i_ctx_wea,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ctx_addr,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
  input  logic                                 i_state_ena,
  input  logic                                 i_state_wea,
  input  logic [STATE_ADDR_WIDTH-1:0]          i_state_addra,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dina,
  output logic                                 o_complete,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dout
);

  localparam int ROW_W = PE_NUM * STATE_DATA_WIDTH;
  localparam int CA    = GATE_CONTEXT_ADDR_WIDTH;
  localparam int IDXW  = STATE_ADDR_WIDTH + PE_NUM_WIDTH;
  localparam int CW    = GATE_CONTEXT_DATA_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ROW_RD, S_EXEC, S_WB, S_DONE} state_t;

  state_t                       r_state, w_next;
  logic [CA-1:0]                r_pc;
  logic [GATE_ADDR_WIDTH-1:0]   r_fcnt;
  logic [7:0]                   r_op, r_t, r_c;
  logic [GATE_DATA_WIDTH-1:0]   r_u [0:3];
  logic [STATE_ADDR_WIDTH-1:0]  r_row;
  logic [CW-1:0]                r_ctx_q;
  logic [ROW_W-1:0]             r_rd_a, r_rd_b, r_wb_a, r_wb_b;
  logic [ROW_W-1:0]             r_state_mem [0:(1<<STATE_ADDR_WIDTH)-1];
  logic [CW-1:0]                r_ctx_mem   [0:(1<<CA)-1];

  logic                         w_pc_load, w_row_inc;
  logic [CA-1:0]                w_pc_new, w_ctx_raddr;
  logic [CA:0]                  w_pc_p1, w_pc_p5;
  logic [7:0]                   w_hdr_op, w_hdr_t, w_hdr_c, w_tq;
  logic                         w_hdr_gate, w_hdr_run, w_hi, w_skip_row, w_last_row;
  logic [MAX_QBIT_WIDTH-1:0]    w_qrow;
  logic [STATE_ADDR_WIDTH-1:0]  w_stride, w_partner, w_rows_m1, w_addr_a;
  logic                         w_we_a, w_we_b;
  logic [ROW_W-1:0]             w_din_a, w_res_a, w_res_b;
  logic [STATE_DATA_WIDTH-1:0]  w_amp [0:2*PE_NUM-1];
  logic [STATE_DATA_WIDTH-1:0]  w_upd [0:2*PE_NUM-1];

  // Q2.30 complex multiply-accumulate: u0*a0 + u1*a1, full-width sums, shift, keep low bits (wraps)
  function automatic logic [STATE_DATA_WIDTH-1:0] cmac(
    input logic [GATE_DATA_WIDTH-1:0]  u0,
    input logic [STATE_DATA_WIDTH-1:0] a0,
    input logic [GATE_DATA_WIDTH-1:0]  u1,
    input logic [STATE_DATA_WIDTH-1:0] a1
  );
    logic signed [ALU_DATA_WIDTH-1:0]   ur0, ui0, ur1, ui1, ar0, ai0, ar1, ai1;
    logic signed [2*ALU_DATA_WIDTH-1:0] sr, si;
    ur0 = u0[GATE_DATA_WIDTH-1 -: ALU_DATA_WIDTH];
    ui0 = u0[ALU_DATA_WIDTH-1:0];
    ur1 = u1[GATE_DATA_WIDTH-1 -: ALU_DATA_WIDTH];
    ui1 = u1[ALU_DATA_WIDTH-1:0];
    ar0 = a0[STATE_DATA_WIDTH-1 -: ALU_DATA_WIDTH];
    ai0 = a0[ALU_DATA_WIDTH-1:0];
    ar1 = a1[STATE_DATA_WIDTH-1 -: ALU_DATA_WIDTH];
    ai1 = a1[ALU_DATA_WIDTH-1:0];
    sr = ur0 * ar0 - ui0 * ai0 + ur1 * ar1 - ui1 * ai1;
    si = ur0 * ai0 + ui0 * ar0 + ur1 * ai1 + ui1 * ar1;
    sr = sr >>> NUM_FRAC_BIT;
    si = si >>> NUM_FRAC_BIT;
    return {sr[DATA_WIDTH-1:0], si[DATA_WIDTH-1:0]};
  endfunction

  // Header decode (valid while r_fcnt==1) and row-pair geometry for the current gate
  assign w_hdr_op    = r_ctx_q[CW-1 -: 8];
  assign w_hdr_t     = r_ctx_q[CW-9 -: 8];
  assign w_hdr_c     = r_ctx_q[CW-17 -: 8];
  assign w_hdr_gate  = (w_hdr_op == 8'h01) || (w_hdr_op == 8'h02);
  assign w_hdr_run   = w_hdr_gate && (int'(w_hdr_t) < int'(i_qbit_num)) &&
                       ((w_hdr_op != 8'h02) || (int'(w_hdr_c) < int'(i_qbit_num)));
  assign w_pc_p1     = {1'b0, r_pc} + (CA+1)'(1);
  assign w_pc_p5     = {1'b0, r_pc} + (CA+1)'(5);
  assign w_ctx_raddr = r_pc + CA'(r_fcnt);
  assign w_hi        = (r_t >= 8'(PE_NUM_WIDTH));
  assign w_tq        = r_t - 8'(PE_NUM_WIDTH);
  assign w_stride    = w_hi ? (STATE_ADDR_WIDTH'(1) << w_tq) : '0;
  assign w_partner   = r_row | w_stride;
  assign w_skip_row  = (r_row & w_stride) != '0;
  assign w_qrow      = i_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
  assign w_rows_m1   = (STATE_ADDR_WIDTH'(1) << w_qrow) - STATE_ADDR_WIDTH'(1);
  assign w_last_row  = (r_row == w_rows_m1);

  // State RAM port muxing: host owns port A only in IDLE, engine writes both rows in WB
  assign w_addr_a = (r_state == S_IDLE) ? i_state_addra : r_row;
  assign w_din_a  = (r_state == S_IDLE) ? i_state_dina : r_wb_a;
  assign w_we_a   = ((r_state == S_IDLE) && i_state_ena && i_state_wea) || (r_state == S_WB);
  assign w_we_b   = (r_state == S_WB) && w_hi;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic plus program-counter and row-step strobes
  always_comb begin
    w_next    = r_state;
    w_pc_load = 1'b0;
    w_pc_new  = r_pc;
    w_row_inc = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_FETCH;
      S_FETCH: begin
        if (r_fcnt == GATE_ADDR_WIDTH'(1)) begin
          if (w_hdr_op == 8'h00) begin
            w_next = S_DONE;
          end else if (!w_hdr_run) begin
            // NOP: skip the header, plus the matrix words of an out-of-range gate
            w_pc_load = 1'b1;
            w_pc_new  = w_hdr_gate ? w_pc_p5[CA-1:0] : w_pc_p1[CA-1:0];
            if (w_hdr_gate ? w_pc_p5[CA] : w_pc_p1[CA]) w_next = S_DONE;
          end
        end else if (r_fcnt == GATE_ADDR_WIDTH'(5)) begin
          w_next = S_ROW_RD;
        end
      end
      S_ROW_RD: begin
        if (!w_skip_row)      w_next = S_EXEC;
        else if (!w_last_row) w_row_inc = 1'b1;
        else begin
          w_pc_load = 1'b1;
          w_pc_new  = w_pc_p5[CA-1:0];
          w_next    = w_pc_p5[CA] ? S_DONE : S_FETCH;
        end
      end
      S_EXEC: w_next = S_WB;
      S_WB: begin
        if (!w_last_row) begin
          w_row_inc = 1'b1;
          w_next    = S_ROW_RD;
        end else begin
          w_pc_load = 1'b1;
          w_pc_new  = w_pc_p5[CA-1:0];
          w_next    = w_pc_p5[CA] ? S_DONE : S_FETCH;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Control registers: pc, fetch step, row counter, decoded gate, completion flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= '0;
      r_fcnt     <= '0;
      r_row      <= '0;
      r_op       <= '0;
      r_t        <= '0;
      r_c        <= '0;
      r_u[0]     <= '0;
      r_u[1]     <= '0;
      r_u[2]     <= '0;
      r_u[3]     <= '0;
      r_wb_a     <= '0;
      r_wb_b     <= '0;
      o_complete <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && i_start) r_pc <= '0;
      else if (w_pc_load)                 r_pc <= w_pc_new;
      if ((r_state == S_FETCH) && (w_next == S_FETCH) && !w_pc_load) r_fcnt <= r_fcnt + GATE_ADDR_WIDTH'(1);
      else                                                           r_fcnt <= '0;
      if (r_state == S_FETCH) r_row <= '0;
      else if (w_row_inc)     r_row <= r_row + STATE_ADDR_WIDTH'(1);
      if ((r_state == S_FETCH) && (r_fcnt == GATE_ADDR_WIDTH'(1))) begin
        r_op <= w_hdr_op;
        r_t  <= w_hdr_t;
        r_c  <= w_hdr_c;
      end
      for (int k = 0; k < 4; k++) begin
        if ((r_state == S_FETCH) && (r_fcnt == GATE_ADDR_WIDTH'(k + 2))) r_u[k] <= r_ctx_q;
      end
      if (r_state == S_EXEC) begin
        r_wb_a <= w_res_a;
        r_wb_b <= w_res_b;
      end
      if (r_state == S_DONE)                   o_complete <= 1'b1;
      else if ((r_state == S_IDLE) && i_start) o_complete <= 1'b0;
    end
  end

  // Butterfly over the fetched row(s): in-row pairs for low targets, PE-aligned row pairs otherwise
  always_comb begin
    for (int p = 0; p < PE_NUM; p++) begin
      w_amp[p]          = r_rd_a[(PE_NUM-p)*STATE_DATA_WIDTH-1 -: STATE_DATA_WIDTH];
      w_amp[PE_NUM + p] = r_rd_b[(PE_NUM-p)*STATE_DATA_WIDTH-1 -: STATE_DATA_WIDTH];
    end
    w_upd = w_amp;
    for (int p = 0; p < PE_NUM; p++) begin
      int             ia, ib;
      logic           pair_ok, ctl_ok;
      logic [IDXW-1:0] idx;
      ia      = p;
      ib      = w_hi ? (PE_NUM + p) : (p | (1 << r_t));
      pair_ok = w_hi || (((p >> r_t) & 1) == 0);
      idx     = {r_row, PE_NUM_WIDTH'(p)};
      ctl_ok  = (r_op != 8'h02) || (((idx >> r_c) & IDXW'(1)) != '0);
      if (pair_ok && ctl_ok) begin
        w_upd[ia] = cmac(r_u[0], w_amp[ia], r_u[1], w_amp[ib]);
        w_upd[ib] = cmac(r_u[2], w_amp[ia], r_u[3], w_amp[ib]);
      end
    end
    w_res_a = '0;
    w_res_b = '0;
    for (int p = 0; p < PE_NUM; p++) begin
      w_res_a[(PE_NUM-p)*STATE_DATA_WIDTH-1 -: STATE_DATA_WIDTH] = w_upd[p];
      w_res_b[(PE_NUM-p)*STATE_DATA_WIDTH-1 -: STATE_DATA_WIDTH] = w_upd[PE_NUM + p];
    end
  end

  // State RAM: engine row/partner reads and write-back (contents survive reset)
  always_ff @(posedge clk) begin
    if (w_we_a) r_state_mem[w_addr_a] <= w_din_a;
    if (w_we_b) r_state_mem[w_partner] <= r_wb_b;
    if (r_state == S_ROW_RD) begin
      r_rd_a <= r_state_mem[w_addr_a];
      r_rd_b <= r_state_mem[w_partner];
    end
  end

  // Host read-back register: old row contents, read-before-write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   o_state_dout <= '0;
    else if ((r_state == S_IDLE) && i_state_ena) o_state_dout <= r_state_mem[i_state_addra];
  end

  // Gate-context RAM: host writes only in IDLE, engine reads with one cycle latency
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && i_ctx_en && i_ctx_wea) r_ctx_mem[i_ctx_addr] <= i_ctx_data;
    r_ctx_q <= r_ctx_mem[w_ctx_raddr];
  end

endmodule

// File: tb/tb_qea_core.sv
// tb_qea_core: directed bench for qea_core with a queue of expected read-back rows.
module tb_qea_core;

  localparam logic [63:0] ONE  = 64'h40000000_00000000;
  localparam logic [63:0] HP   = 64'h2D413CCC_00000000;
  localparam logic [63:0] HN   = 64'hD2BEC334_00000000;
  localparam logic [63:0] Z    = 64'h0;
  localparam logic [63:0] XEND = 64'h0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic [5:0]   i_qbit_num = 6'd10;
  logic         i_ctx_en = 1'b0, i_ctx_wea = 1'b0;
  logic [15:0]  i_ctx_addr = '0;
  logic [63:0]  i_ctx_data = '0;
  logic         i_state_ena = 1'b0, i_state_wea = 1'b0;
  logic [15:0]  i_state_addra = '0;
  logic [255:0] i_state_dina = '0;
  logic         o_complete;
  logic [255:0] o_state_dout;

  int checks = 0;
  int errors = 0;
  logic [255:0] exp_q[$];
  logic [255:0] pat;

  always #5 clk = ~clk;

  qea_core dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_qbit_num(i_qbit_num),
    .i_ctx_en(i_ctx_en), .i_ctx_wea(i_ctx_wea), .i_ctx_addr(i_ctx_addr), .i_ctx_data(i_ctx_data),
    .i_state_ena(i_state_ena), .i_state_wea(i_state_wea), .i_state_addra(i_state_addra),
    .i_state_dina(i_state_dina), .o_complete(o_complete), .o_state_dout(o_state_dout)
  );

  function automatic logic [255:0] mk_row(input logic [63:0] a0, a1, a2, a3);
    return {a0, a1, a2, a3};
  endfunction

  function automatic logic [63:0] hdr(input logic [7:0] op, t, c);
    return {op, t, c, 40'd0};
  endfunction

  task automatic check_row(input string tag, input logic [255:0] got);
    logic [255:0] exp;
    exp = exp_q.pop_front();
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic ctx_wr(input logic [15:0] a, input logic [63:0] d);
    i_ctx_en = 1'b1; i_ctx_wea = 1'b1; i_ctx_addr = a; i_ctx_data = d;
    @(negedge clk);
    i_ctx_en = 1'b0; i_ctx_wea = 1'b0;
  endtask

  task automatic load_gate(input logic [15:0] b, input logic [7:0] op, t, c,
                           input logic [63:0] u00, u01, u10, u11);
    ctx_wr(b, hdr(op, t, c));
    ctx_wr(b + 16'd1, u00);
    ctx_wr(b + 16'd2, u01);
    ctx_wr(b + 16'd3, u10);
    ctx_wr(b + 16'd4, u11);
  endtask

  task automatic row_wr(input logic [15:0] a, input logic [255:0] d);
    i_state_ena = 1'b1; i_state_wea = 1'b1; i_state_addra = a; i_state_dina = d;
    @(negedge clk);
    i_state_ena = 1'b0; i_state_wea = 1'b0;
  endtask

  task automatic row_rd(input string tag, input logic [15:0] a, input logic [255:0] exp,
                        input logic we, input logic [255:0] d);
    i_state_ena = 1'b1; i_state_wea = we; i_state_addra = a; i_state_dina = d;
    exp_q.push_back(exp);
    @(negedge clk);
    i_state_ena = 1'b0; i_state_wea = 1'b0;
    check_row(tag, o_state_dout);
  endtask

  task automatic init_state();
    for (int i = 0; i < 256; i++) row_wr(16'(i), '0);
    row_wr(16'd0, mk_row(ONE, Z, Z, Z));
  endtask

  task automatic start_pulse();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!o_complete && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_bit(tag, o_complete, 1'b1);
  endtask

  initial begin
    pat = {4{64'hA5A5_0001_5A5A_0002}};
    repeat (3) @(negedge clk);
    // reset values
    check_bit("rst_complete", o_complete, 1'b0);
    exp_q.push_back('0);
    check_row("rst_dout", o_state_dout);
    rst_n = 1'b1;
    @(negedge clk);

    // END only: completes fast, state untouched
    init_state();
    ctx_wr(16'd0, hdr(8'h00, 8'h00, 8'h00));
    start_pulse();
    wait_done("end_done", 10);
    row_rd("end_row0", 16'd0, mk_row(ONE, Z, Z, Z), 1'b0, '0);

    // Hadamard on qubit 0
    init_state();
    load_gate(16'd0, 8'h01, 8'd0, 8'd0, HP, HP, HP, HN);
    ctx_wr(16'd5, XEND);
    start_pulse();
    wait_done("h_done", 1100);
    row_rd("h_row0", 16'd0, mk_row(HP, HP, Z, Z), 1'b0, '0);
    row_rd("h_row1", 16'd1, mk_row(Z, Z, Z, Z), 1'b0, '0);
    row_rd("h_row128", 16'd128, mk_row(Z, Z, Z, Z), 1'b0, '0);

    // X on qubit 5 (cross-row partner 8)
    init_state();
    load_gate(16'd0, 8'h01, 8'd5, 8'd0, Z, ONE, ONE, Z);
    ctx_wr(16'd5, XEND);
    start_pulse();
    wait_done("x5_done", 1100);
    row_rd("x5_row8", 16'd8, mk_row(ONE, Z, Z, Z), 1'b0, '0);
    row_rd("x5_row0", 16'd0, mk_row(Z, Z, Z, Z), 1'b0, '0);

    // X t=0 then CNOT c=0 t=1 -> index 3
    init_state();
    load_gate(16'd0, 8'h01, 8'd0, 8'd0, Z, ONE, ONE, Z);
    load_gate(16'd5, 8'h02, 8'd1, 8'd0, Z, ONE, ONE, Z);
    ctx_wr(16'd10, XEND);
    start_pulse();
    wait_done("cx_done", 2200);
    row_rd("cx_row0", 16'd0, mk_row(Z, Z, Z, ONE), 1'b0, '0);

    // unknown opcode, target out of range, control out of range: all NOPs
    init_state();
    ctx_wr(16'd0, hdr(8'h07, 8'd0, 8'd0));
    load_gate(16'd1, 8'h01, 8'd12, 8'd0, Z, ONE, ONE, Z);
    load_gate(16'd6, 8'h02, 8'd0, 8'd11, Z, ONE, ONE, Z);
    ctx_wr(16'd11, XEND);
    start_pulse();
    wait_done("nop_done", 40);
    row_rd("nop_row0", 16'd0, mk_row(ONE, Z, Z, Z), 1'b0, '0);

    // host traffic and start pulses during a run are ignored
    init_state();
    load_gate(16'd0, 8'h01, 8'd5, 8'd0, Z, ONE, ONE, Z);
    ctx_wr(16'd5, XEND);
    start_pulse();
    repeat (2) @(negedge clk);
    row_wr(16'd8, '1);
    row_wr(16'd0, pat);
    i_state_ena = 1'b1; i_state_addra = 16'd0;
    start_pulse();
    i_state_ena = 1'b0;
    repeat (3) @(negedge clk);
    start_pulse();
    wait_done("busy_done", 1100);
    row_rd("busy_rbw_row8", 16'd8, mk_row(ONE, Z, Z, Z), 1'b1, pat);
    row_rd("busy_new_row8", 16'd8, pat, 1'b0, '0);
    row_rd("busy_row0", 16'd0, mk_row(Z, Z, Z, Z), 1'b0, '0);

    // reset mid-run aborts, then a fresh run completes
    row_wr(16'd8, '0);
    row_wr(16'd0, mk_row(ONE, Z, Z, Z));
    start_pulse();
    repeat (20) @(negedge clk);
    check_bit("mid_running", o_complete, 1'b0);
    rst_n = 1'b0;
    #1;
    check_bit("mid_rst_complete", o_complete, 1'b0);
    exp_q.push_back('0);
    check_row("mid_rst_dout", o_state_dout);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    row_wr(16'd8, '0);
    row_wr(16'd0, mk_row(ONE, Z, Z, Z));
    start_pulse();
    wait_done("rerun_done", 1100);
    row_rd("rerun_row8", 16'd8, mk_row(ONE, Z, Z, Z), 1'b0, '0);
    row_rd("rerun_row0", 16'd0, mk_row(Z, Z, Z, Z), 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
